// File: rtl/dht11_sensor_model.sv
// ---------------------------------------------------------------------------
// dht11_sensor_model
//   Responder end of the DHT11 single-wire protocol. Waits for a host start
//   pulse, then answers with the 80/80 us preamble and a 40-bit frame made of
//   sensor_data (MSB first) followed by an 8-bit checksum.
// Ports
//   clk25M        in     system clock (only clock)
//   rst_n         in     synchronous active-low reset
//   io_dht11      inout  open-drain bus: driven 0 or Z only, external pull-up
//   sensor_data   in     {humi_int, humi_dec, temp_int, temp_dec}
//   err_checksum  in     1 = send the inverted checksum
//   busy          out    high from start accept until frame_done
//   frame_done    out    1-cycle pulse once the frame is out and bus is high
// ---------------------------------------------------------------------------
module dht11_sensor_model #(
  parameter int unsigned CLK_PER_US     = 25,
  parameter int unsigned T_START_MIN_US = 18000,
  parameter int unsigned T_RESP_DLY_US  = 30,
  parameter int unsigned T_RESP_LOW_US  = 80,
  parameter int unsigned T_RESP_HIGH_US = 80,
  parameter int unsigned T_BIT_LOW_US   = 50,
  parameter int unsigned T_BIT0_HIGH_US = 26,
  parameter int unsigned T_BIT1_HIGH_US = 70
) (
  input  logic        clk25M,
  input  logic        rst_n,
  inout  wire         io_dht11,
  input  logic [31:0] sensor_data,
  input  logic        err_checksum,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START_LOW, ST_RESP_DLY, ST_RESP_LOW, ST_RESP_HIGH,
    ST_BIT_LOW, ST_BIT_HIGH, ST_EOF_LOW, ST_DONE
  } state_t;

  localparam int unsigned TW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  // A phase of N us ends on the tick where ph_cnt == N-1.
  localparam logic [19:0] START_MIN     = 20'(T_START_MIN_US);
  localparam logic [19:0] LAST_RESP_DLY = 20'(T_RESP_DLY_US - 1);
  localparam logic [19:0] LAST_RESP_LOW = 20'(T_RESP_LOW_US - 1);
  localparam logic [19:0] LAST_RESP_HI  = 20'(T_RESP_HIGH_US - 1);
  localparam logic [19:0] LAST_BIT_LOW  = 20'(T_BIT_LOW_US - 1);
  localparam logic [19:0] LAST_BIT0_HI  = 20'(T_BIT0_HIGH_US - 1);
  localparam logic [19:0] LAST_BIT1_HI  = 20'(T_BIT1_HIGH_US - 1);

  state_t         state_q, state_d;
  logic           sync1_q, sync2_q;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [19:0]    ph_cnt_q, ph_cnt_d;
  logic [39:0]    shreg_q, shreg_d;
  logic [5:0]     bit_idx_q, bit_idx_d;
  logic           drv_low_q, drv_low_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;

  logic           line_s;
  logic           us_tick;
  logic [19:0]    ph_last;
  logic           ph_end;
  logic [7:0]     csum;

  assign io_dht11   = drv_low_q ? 1'b0 : 1'bz;
  assign line_s     = sync2_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  assign us_tick    = (tick_cnt_q == TW'(CLK_PER_US - 1));
  assign tick_cnt_d = us_tick ? '0 : tick_cnt_q + TW'(1);

  always_comb begin
    csum = sensor_data[31:24] + sensor_data[23:16] + sensor_data[15:8] + sensor_data[7:0];
    if (err_checksum) csum = ~csum;
  end

  always_comb begin
    case (state_q)
      ST_RESP_DLY:  ph_last = LAST_RESP_DLY;
      ST_RESP_LOW:  ph_last = LAST_RESP_LOW;
      ST_RESP_HIGH: ph_last = LAST_RESP_HI;
      ST_BIT_LOW:   ph_last = LAST_BIT_LOW;
      ST_EOF_LOW:   ph_last = LAST_BIT_LOW;
      ST_BIT_HIGH:  ph_last = shreg_q[39] ? LAST_BIT1_HI : LAST_BIT0_HI;
      default:      ph_last = '1;
    endcase
  end

  assign ph_end = us_tick && (ph_cnt_q == ph_last);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE:      if (!line_s) state_d = ST_START_LOW;
      ST_START_LOW: if (line_s) begin
        if (ph_cnt_q >= START_MIN) begin
          state_d   = ST_RESP_DLY;
          busy_d    = 1'b1;
          shreg_d   = {sensor_data, csum};
          bit_idx_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP_DLY:  if (ph_end) state_d = ST_RESP_LOW;
      ST_RESP_LOW:  if (ph_end) state_d = ST_RESP_HIGH;
      ST_RESP_HIGH: if (ph_end) state_d = ST_BIT_LOW;
      ST_BIT_LOW:   if (ph_end) state_d = ST_BIT_HIGH;
      ST_BIT_HIGH:  if (ph_end) begin
        shreg_d   = {shreg_q[38:0], 1'b0};
        bit_idx_d = bit_idx_q + 6'd1;
        state_d   = (bit_idx_q == 6'd39) ? ST_EOF_LOW : ST_BIT_LOW;
      end
      ST_EOF_LOW:   if (ph_end) state_d = ST_DONE;
      // Our own final low is still in the synchroniser; wait for it to clear.
      ST_DONE:      if (line_s) begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        bit_idx_d    = '0;
        state_d      = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase

    if (state_d != state_q)
      ph_cnt_d = '0;
    else if (us_tick && (ph_cnt_q != '1))
      ph_cnt_d = ph_cnt_q + 20'd1;
    else
      ph_cnt_d = ph_cnt_q;

    // drv_low follows the next state so the bus level lines up with state_q.
    drv_low_d = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) ||
                (state_d == ST_EOF_LOW);
  end

  always_ff @(posedge clk25M) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      tick_cnt_q   <= '0;
      ph_cnt_q     <= '0;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      drv_low_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= io_dht11;
      sync2_q      <= sync1_q;
      tick_cnt_q   <= tick_cnt_d;
      ph_cnt_q     <= ph_cnt_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      drv_low_q    <= drv_low_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_dht11_sensor_model.sv
// ---------------------------------------------------------------------------
// tb_dht11_sensor_model
//   Drives host start pulses onto the open-drain bus, decodes the responder's
//   waveform (preamble, 40 bits, end-of-frame low) and compares the decoded
//   frame and phase widths against expectations queued at stimulus time.
//   Timing is scaled down (2 clk per us, 200 us start minimum) to keep runs short.
// ---------------------------------------------------------------------------
module tb_dht11_sensor_model;

  localparam int C       = 2;    // clk cycles per us in this bench
  localparam int T_START = 200;  // scaled start-request minimum, us

  logic        clk25M = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_low = 1'b0;
  logic [31:0] sensor_data = '0;
  logic        err_checksum = 1'b0;
  logic        busy, frame_done;
  wire         io_dht11;

  pullup (io_dht11);
  assign io_dht11 = host_low ? 1'b0 : 1'bz;

  always #20 clk25M = ~clk25M;

  dht11_sensor_model #(
    .CLK_PER_US     (C),
    .T_START_MIN_US (T_START)
  ) dut (
    .clk25M       (clk25M),
    .rst_n        (rst_n),
    .io_dht11     (io_dht11),
    .sensor_data  (sensor_data),
    .err_checksum (err_checksum),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [39:0] exp_q[$];

  logic [39:0] cap_bits;
  int          cap_dev;
  int          cap_done;
  logic        cap_busy_mid, cap_busy_end;
  logic        cap_to;

  function automatic logic [39:0] model_frame(input logic [31:0] d, input logic e);
    logic [7:0] s;
    s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
    if (e) s = ~s;
    return {d, s};
  endfunction

  task automatic host_start(input int us);
    @(negedge clk25M);
    host_low = 1'b1;
    repeat (us * C) @(negedge clk25M);
    host_low = 1'b0;
  endtask

  task automatic note_dev(input int len, input int us);
    int d;
    d = len - us * C;
    if (d < 0) d = -d;
    if (d > cap_dev) cap_dev = d;
  endtask

  task automatic measure(input logic lvl, output int len);
    len = 0;
    while (io_dht11 === lvl && len < 400 * C) begin
      @(negedge clk25M);
      len++;
    end
    if (len >= 400 * C) cap_to = 1'b1;
  endtask

  task automatic capture_frame();
    int w, lo, hi;
    cap_to = 1'b0; cap_bits = '0; cap_dev = 0; cap_done = 0;
    cap_busy_mid = 1'b0; cap_busy_end = 1'b1;
    w = 0;
    @(negedge clk25M);
    while (io_dht11 !== 1'b0 && w < 400 * C) begin
      @(negedge clk25M);
      w++;
    end
    if (w >= 400 * C) begin cap_to = 1'b1; return; end
    cap_busy_mid = busy;
    measure(1'b0, lo); note_dev(lo, 80);
    measure(1'b1, hi); note_dev(hi, 80);
    for (int i = 0; i < 40 && !cap_to; i++) begin
      measure(1'b0, lo); note_dev(lo, 50);
      measure(1'b1, hi);
      if (hi > 48 * C) begin cap_bits = {cap_bits[38:0], 1'b1}; note_dev(hi, 70); end
      else             begin cap_bits = {cap_bits[38:0], 1'b0}; note_dev(hi, 26); end
    end
    if (cap_to) return;
    measure(1'b0, lo); note_dev(lo, 50);
    for (int i = 0; i < 20; i++) begin
      if (frame_done === 1'b1) cap_done++;
      @(negedge clk25M);
    end
    cap_busy_end = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_low = 1'b0;
    repeat (3) @(negedge clk25M);
    n_checks++; if (io_dht11 !== 1'b1) $display("FAIL reset_bus: got %b want 1", io_dht11); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done); else n_pass++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk25M);
  endtask

  task automatic test_basic_frame();
    logic [39:0] e;
    sensor_data = 32'h3A00_1905; err_checksum = 1'b0;
    exp_q.push_back(model_frame(sensor_data, err_checksum));
    host_start(T_START + 50);
    repeat (10) @(negedge clk25M);
    sensor_data = 32'hDEAD_BEEF; err_checksum = 1'b1;  // must not reach the frame in flight
    capture_frame();
    e = exp_q.pop_front();
    n_checks++; if (cap_to !== 1'b0) $display("FAIL basic_timeout: got %b want 0", cap_to); else n_pass++;
    n_checks++; if (cap_bits !== e) $display("FAIL basic_bits: got %h want %h", cap_bits, e); else n_pass++;
    n_checks++; if (!(cap_dev <= C)) $display("FAIL basic_timing: dev %0d want <= %0d", cap_dev, C); else n_pass++;
    n_checks++; if (cap_busy_mid !== 1'b1) $display("FAIL basic_busy_mid: got %b want 1", cap_busy_mid); else n_pass++;
    n_checks++; if (cap_done !== 1) $display("FAIL basic_done_cnt: got %0d want 1", cap_done); else n_pass++;
    n_checks++; if (cap_busy_end !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", cap_busy_end); else n_pass++;
  endtask

  task automatic test_glitch();
    int lows, busies, dones, p;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? 50 : T_START - 20;
      host_start(p);
      lows = 0; busies = 0; dones = 0;
      repeat (300 * C) begin
        @(negedge clk25M);
        if (io_dht11 === 1'b0) lows++;
        if (busy === 1'b1) busies++;
        if (frame_done === 1'b1) dones++;
      end
      n_checks++; if (lows !== 0) $display("FAIL glitch%0d_bus_low: got %0d want 0", k, lows); else n_pass++;
      n_checks++; if (busies !== 0) $display("FAIL glitch%0d_busy: got %0d want 0", k, busies); else n_pass++;
      n_checks++; if (dones !== 0) $display("FAIL glitch%0d_done: got %0d want 0", k, dones); else n_pass++;
    end
  endtask

  task automatic test_wrap_min_start();
    logic [39:0] e;
    sensor_data = 32'hFFFF_FFFF; err_checksum = 1'b0;
    exp_q.push_back(model_frame(sensor_data, err_checksum));
    host_start(T_START + 10);
    capture_frame();
    e = exp_q.pop_front();
    n_checks++; if (cap_to !== 1'b0) $display("FAIL wrap_timeout: got %b want 0", cap_to); else n_pass++;
    n_checks++; if (cap_bits !== e) $display("FAIL wrap_bits: got %h want %h", cap_bits, e); else n_pass++;
    n_checks++; if (!(cap_dev <= C)) $display("FAIL wrap_timing: dev %0d want <= %0d", cap_dev, C); else n_pass++;
    n_checks++; if (cap_done !== 1) $display("FAIL wrap_done_cnt: got %0d want 1", cap_done); else n_pass++;
  endtask

  task automatic test_err_checksum();
    logic [39:0] e;
    sensor_data = 32'h3A00_1905; err_checksum = 1'b1;
    exp_q.push_back(model_frame(sensor_data, err_checksum));
    host_start(T_START + 50);
    repeat (10) @(negedge clk25M);
    err_checksum = 1'b0;
    capture_frame();
    e = exp_q.pop_front();
    n_checks++; if (cap_to !== 1'b0) $display("FAIL errcs_timeout: got %b want 0", cap_to); else n_pass++;
    n_checks++; if (cap_bits !== e) $display("FAIL errcs_bits: got %h want %h", cap_bits, e); else n_pass++;
    n_checks++; if (cap_bits[7:0] !== 8'hA7) $display("FAIL errcs_byte: got %h want a7", cap_bits[7:0]); else n_pass++;
    n_checks++; if (cap_done !== 1) $display("FAIL errcs_done_cnt: got %0d want 1", cap_done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [39:0] e;
    logic [31:0] d[2];
    d[0] = 32'h1234_5678;
    d[1] = $urandom;
    for (int k = 0; k < 2; k++) begin
      sensor_data = d[k]; err_checksum = 1'b0;
      exp_q.push_back(model_frame(sensor_data, err_checksum));
      host_start(T_START + 30);
      capture_frame();
      e = exp_q.pop_front();
      n_checks++; if (cap_to !== 1'b0) $display("FAIL b2b%0d_timeout: got %b want 0", k, cap_to); else n_pass++;
      n_checks++; if (cap_bits !== e) $display("FAIL b2b%0d_bits: got %h want %h", k, cap_bits, e); else n_pass++;
      n_checks++; if (!(cap_dev <= C)) $display("FAIL b2b%0d_timing: dev %0d want <= %0d", k, cap_dev, C); else n_pass++;
      n_checks++; if (cap_done !== 1) $display("FAIL b2b%0d_done_cnt: got %0d want 1", k, cap_done); else n_pass++;
      n_checks++; if (cap_busy_end !== 1'b0) $display("FAIL b2b%0d_busy_end: got %b want 0", k, cap_busy_end); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int edges, w, lows, busies, dones;
    logic prev;
    logic [39:0] e;
    sensor_data = 32'h5AA5_0F0F; err_checksum = 1'b0;
    host_start(T_START + 50);
    edges = 0; w = 0; prev = 1'b1;
    // falling edge 1 is the preamble, edge k+2 starts the low before bit k
    while (edges < 22 && w < 20000 * C) begin
      @(negedge clk25M);
      w++;
      if (prev === 1'b1 && io_dht11 === 1'b0) edges++;
      prev = io_dht11;
    end
    n_checks++; if (edges !== 22) $display("FAIL midrst_reach_bit20: got %0d edges want 22", edges); else n_pass++;
    repeat (5) @(negedge clk25M);
    rst_n = 1'b0;
    @(posedge clk25M);
    #1;
    n_checks++; if (io_dht11 !== 1'b1) $display("FAIL midrst_bus: got %b want 1", io_dht11); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    repeat (3) @(negedge clk25M);
    rst_n = 1'b1;
    lows = 0; busies = 0; dones = 0;
    repeat (300 * C) begin
      @(negedge clk25M);
      if (io_dht11 === 1'b0) lows++;
      if (busy === 1'b1) busies++;
      if (frame_done === 1'b1) dones++;
    end
    n_checks++; if (lows !== 0) $display("FAIL midrst_no_resume: got %0d low cycles want 0", lows); else n_pass++;
    n_checks++; if (busies + dones !== 0) $display("FAIL midrst_idle: got %0d busy/done cycles want 0", busies + dones); else n_pass++;

    sensor_data = 32'h3A00_1905;
    exp_q.push_back(model_frame(sensor_data, err_checksum));
    host_start(T_START + 50);
    capture_frame();
    e = exp_q.pop_front();
    n_checks++; if (cap_to !== 1'b0) $display("FAIL postrst_timeout: got %b want 0", cap_to); else n_pass++;
    n_checks++; if (cap_bits !== e) $display("FAIL postrst_bits: got %h want %h", cap_bits, e); else n_pass++;
    n_checks++; if (!(cap_dev <= C)) $display("FAIL postrst_timing: dev %0d want <= %0d", cap_dev, C); else n_pass++;
    n_checks++; if (cap_done !== 1) $display("FAIL postrst_done_cnt: got %0d want 1", cap_done); else n_pass++;
  endtask

  initial begin
    repeat (150000) @(posedge clk25M);
    $display("FAIL watchdog: run exceeded 150000 cycles, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_wrap_min_start();
    test_err_checksum();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
